// File: rtl/mmu_bus_pkg.sv
// Shared encodings for the MMU bus sequencer: access types, response causes
// and sequencer states.
package mmu_bus_pkg;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_R    = 2'd1;
  localparam logic [1:0] ACC_W    = 2'd2;
  localparam logic [1:0] ACC_X    = 2'd3;

  localparam logic [1:0] CAUSE_OK   = 2'd0;
  localparam logic [1:0] CAUSE_XLAT = 2'd1;
  localparam logic [1:0] CAUSE_TMO  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XLAT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr (mod N)
// wins. The pointer register belongs to the parent.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // Walk the ports starting at ptr and stop at the first active request
  always_comb begin
    grant   = {N{1'b0}};
    idx     = {IW{1'b0}};
    found_s = 1'b0;
    sum_s   = {(IW+1){1'b0}};
    cand_s  = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr} + (IW+1)'(i);
      if (sum_s >= (IW+1)'(N)) begin
        sum_s = sum_s - (IW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mmu_bus_sequencer.sv
// Multi-port virtual-address bus sequencer: round-robin grant, MMU translation
// handshake, physical bus access with optional timeout, one-cycle response.
module mmu_bus_sequencer
  import mmu_bus_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic [2*N_PORTS-1:0]    req_type,
  input  logic [ADDR_W*N_PORTS-1:0] req_vaddr,
  input  logic [DATA_W*N_PORTS-1:0] req_wdata,
  output logic [N_PORTS-1:0]      req_ready,
  output logic [DATA_W-1:0]       req_rdata,
  output logic [1:0]              req_cause,
  output logic                    xlat_req,
  output logic [ADDR_W-1:0]       xlat_vaddr,
  output logic [1:0]              xlat_type,
  input  logic                    xlat_done,
  input  logic [ADDR_W-1:0]       xlat_paddr,
  input  logic                    xlat_fault,
  output logic [1:0]              mem_type,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ready,
  output logic                    busy
);

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state_r;
  logic [IW-1:0]       ptr_r;
  logic [IW-1:0]       grant_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [CW-1:0]       cnt_r;

  logic [N_PORTS-1:0]  req_vec_s;
  logic [N_PORTS-1:0]  gnt_s;
  logic [IW-1:0]       gidx_s;
  logic [1:0]          sel_type_s;
  logic [ADDR_W-1:0]   sel_vaddr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [N_PORTS-1:0]  ready_mask_s;

  rr_arbiter #(.N(N_PORTS)) u_arb (
    .req   (req_vec_s),
    .ptr   (ptr_r),
    .grant (gnt_s),
    .idx   (gidx_s)
  );

  // Request vector and one-hot AND-OR mux of the winning port's fields
  always_comb begin
    req_vec_s   = {N_PORTS{1'b0}};
    sel_type_s  = 2'b00;
    sel_vaddr_s = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_PORTS; i++) begin
      req_vec_s[i] = (req_type[2*i +: 2] != ACC_NONE);
      sel_type_s   = sel_type_s  | (req_type[2*i +: 2] & {2{gnt_s[i]}});
      sel_vaddr_s  = sel_vaddr_s | (req_vaddr[ADDR_W*i +: ADDR_W] & {ADDR_W{gnt_s[i]}});
      sel_wdata_s  = sel_wdata_s | (req_wdata[DATA_W*i +: DATA_W] & {DATA_W{gnt_s[i]}});
    end
    ready_mask_s          = {N_PORTS{1'b0}};
    ready_mask_s[grant_r] = 1'b1;
  end

  // Sequencer FSM; all outputs are registers, cleared the instant res_n falls
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {IW{1'b0}};
      grant_r    <= {IW{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      req_ready  <= {N_PORTS{1'b0}};
      req_rdata  <= {DATA_W{1'b0}};
      req_cause  <= CAUSE_OK;
      xlat_req   <= 1'b0;
      xlat_vaddr <= {ADDR_W{1'b0}};
      xlat_type  <= ACC_NONE;
      mem_type   <= ACC_NONE;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_vec_s) begin
            grant_r    <= gidx_s;
            ptr_r      <= (gidx_s == IW'(N_PORTS - 1)) ? {IW{1'b0}} : gidx_s + IW'(1);
            xlat_type  <= sel_type_s;
            xlat_vaddr <= sel_vaddr_s;
            wdata_r    <= sel_wdata_s;
            xlat_req   <= 1'b1;
            busy       <= 1'b1;
            state_r    <= ST_XLAT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_XLAT: begin
          if (xlat_done) begin
            xlat_req <= 1'b0;
            if (xlat_fault) begin
              req_ready <= ready_mask_s;
              req_rdata <= {DATA_W{1'b0}};
              req_cause <= CAUSE_XLAT;
              state_r   <= ST_RESP;
            end else begin
              mem_type  <= xlat_type;
              mem_addr  <= xlat_paddr;
              mem_wdata <= wdata_r;
              cnt_r     <= {CW{1'b0}};
              state_r   <= ST_ACCESS;
            end
          end else begin
            state_r <= ST_XLAT;
          end
        end
        ST_ACCESS: begin
          // mem_ready is tested first so a completion on the expiry cycle wins
          if (mem_ready) begin
            mem_type  <= ACC_NONE;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            req_ready <= ready_mask_s;
            req_rdata <= mem_rdata;
            req_cause <= CAUSE_OK;
            state_r   <= ST_RESP;
          end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
            mem_type  <= ACC_NONE;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            req_ready <= ready_mask_s;
            req_rdata <= {DATA_W{1'b0}};
            req_cause <= CAUSE_TMO;
            state_r   <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RESP: begin
          req_ready <= {N_PORTS{1'b0}};
          req_rdata <= {DATA_W{1'b0}};
          req_cause <= CAUSE_OK;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mmu_bus_sequencer.md
Name: mmu_bus_sequencer

Overview:
- Parametrised successor of the single-port CPU/MMU bus glue.
- Arbitrates N_PORTS virtual-address requesters (e.g. I-fetch, D-access, DMA) onto one physical data bus.
- Sequences each access through an MMU translation handshake with variable latency.
- Aborts on translation fault or bus timeout; reports a cause code to the granted requester.

Parameters:
- N_PORTS, 2, number of requester ports (1..8).
- ADDR_W, 32, virtual and physical address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max ACCESS cycles without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state on rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- req_type  in  2*N_PORTS  per-port access type (ACC_NONE/R/W/X); held until that port's req_ready.
- req_vaddr  in  ADDR_W*N_PORTS  per-port virtual address.
- req_wdata  in  DATA_W*N_PORTS  per-port write data.
- req_ready  out  N_PORTS  one-cycle completion pulse, granted port only.
- req_rdata  out  DATA_W  read data; valid with req_ready.
- req_cause  out  2  CAUSE_OK/CAUSE_XLAT/CAUSE_TMO; valid with req_ready.
- xlat_req  out  1  translation request, high throughout XLAT.
- xlat_vaddr  out  ADDR_W  latched virtual address.
- xlat_type  out  2  latched access type.
- xlat_done  in  1  translation complete.
- xlat_paddr  in  ADDR_W  physical address; valid with xlat_done.
- xlat_fault  in  1  translation fault; valid with xlat_done.
- mem_type  out  2  physical bus type; ACC_NONE outside ACCESS.
- mem_addr  out  ADDR_W  physical address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid with mem_ready.
- mem_ready  in  1  bus completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (res_n low, asynchronous, effective immediately):
  - State IDLE; round-robin pointer 0.
  - All outputs 0; mem_type = ACC_NONE.
  - Reset mid-access drops the transaction silently; no req_ready is issued.
- States: IDLE, XLAT, ACCESS, RESP.
- IDLE:
  - Samples req_type of all ports.
  - Grants the first port with type != ACC_NONE, searching from the pointer upward (mod N_PORTS).
  - Latches port id, type, vaddr and wdata; goes to XLAT.
  - Pointer becomes grant+1 mod N_PORTS, so the granted port has lowest priority next time.
- XLAT:
  - xlat_req=1 with latched vaddr/type; xlat_done may arrive in the first XLAT cycle.
  - xlat_done && !xlat_fault: latch paddr, go to ACCESS.
  - xlat_done && xlat_fault: cause=CAUSE_XLAT, go to RESP; the bus is never driven.
  - Stays in XLAT indefinitely while xlat_done=0.
- ACCESS:
  - mem_type = latched type, mem_addr = paddr, mem_wdata = latched wdata; all stable for the whole state.
  - mem_ready: capture mem_rdata (writes capture too, value ignored), cause=CAUSE_OK, go to RESP.
  - Timeout: cycle counter starts at 0 on entry. If TIMEOUT != 0 and the TIMEOUT-th ACCESS cycle has mem_ready=0: cause=CAUSE_TMO, rdata=0, go to RESP.
  - mem_ready in the same cycle as expiry wins.
- RESP:
  - req_ready[grant]=1 for exactly one cycle, with req_rdata and req_cause held that cycle.
  - Always returns to IDLE.
  - req_ready, req_rdata and req_cause are 0 outside RESP.
- Latency: min 4 cycles request→req_ready (IDLE, XLAT, ACCESS, RESP), with zero-wait xlat and bus. Throughput is one access per 4 cycles at best.
- The requester must drop or change req_type in the cycle after req_ready; IDLE resamples then.
- Requests that change while not granted are allowed; only the IDLE sample counts.
- Illegal 2'b11 encodings are not possible: ACC_X is the fourth code.

Decomposition:
- Shared package mmu_bus_pkg:
  - ACC_NONE=2'd0, ACC_R=2'd1, ACC_W=2'd2, ACC_X=2'd3.
  - CAUSE_OK=2'd0, CAUSE_XLAT=2'd1, CAUSE_TMO=2'd2.
  - State encodings.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: request vector, pointer. Outputs: one-hot grant and binary index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
1. Single read: port0 R vaddr 0x1000, xlat_done+paddr 0x8000 in first XLAT cycle, mem_ready first ACCESS cycle, mem_rdata 0xDEADBEEF → req_ready[0] at cycle 3, rdata 0xDEADBEEF, cause OK, mem_addr 0x8000 during ACCESS only.
2. Round robin: ports 0 and 1 request continuously → grants alternate 0,1,0,1; no port granted twice in a row while the other waits.
3. Translation fault: port1 W, xlat_done with xlat_fault after 3 cycles → mem_type stays ACC_NONE throughout, req_ready[1] with cause XLAT.
4. Timeout: TIMEOUT=4, mem_ready never → exactly 4 ACCESS cycles, then req_ready with cause TMO and rdata 0.
5. Timeout tie: TIMEOUT=4, mem_ready on 4th ACCESS cycle → cause OK with data.
6. Reset mid-ACCESS: pull res_n low → mem_type ACC_NONE and busy 0 same cycle, no req_ready. After release, a pending request is re-granted starting from port 0.
